// File: rtl/pe_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_scheduler_if
// Brief    : Host/stream and PE-strobe bundle between the array and one
//            pe_scheduler instance.
// Revision : 1.0
// ============================================================================
interface pe_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ITER_W     = 4
);
    logic                    start;
    logic                    samp_in_v;
    logic [2*DATA_WIDTH-1:0] samp_in;
    logic                    stall;
    logic                    samp_ready;
    logic                    din_pe_v;
    logic [2*DATA_WIDTH-1:0] din_pe;
    logic                    inst_go;
    logic                    tx_en;
    logic                    shift_en;
    logic                    alpha_v;
    logic [ITER_W-1:0]       iter_idx;
    logic                    busy;
    logic                    done;

    modport master (
        output start, samp_in_v, samp_in, stall,
        input  samp_ready, din_pe_v, din_pe, inst_go, tx_en, shift_en,
               alpha_v, iter_idx, busy, done
    );

    modport slave (
        input  start, samp_in_v, samp_in, stall,
        output samp_ready, din_pe_v, din_pe, inst_go, tx_en, shift_en,
               alpha_v, iter_idx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pe_scheduler
// Brief    : Sequences one PE through LOAD, (COMPUTE, TRANSMIT, SHIFT) x
//            (ITER_NUM-1), COMPUTE, OUTPUT. Optional freeze: PE_SCHED_STALL_EN.
// Revision : 1.0
// ============================================================================
module pe_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int LOAD_LEN   = 16,
    parameter int CMPT_LEN   = 64,
    parameter int TX_LEN     = 4,
    parameter int SHIFT_LEN  = 8,
    parameter int ITER_NUM   = 8,
    parameter int OUT_LEN    = 4
) (
    input wire logic      clk,
    input wire logic      rst,
    pe_scheduler_if.slave bus
);
    localparam int c_iter_w = $clog2(ITER_NUM) + 1;
    localparam int c_max_a  = (LOAD_LEN > CMPT_LEN) ? LOAD_LEN : CMPT_LEN;
    localparam int c_max_b  = (TX_LEN > SHIFT_LEN) ? TX_LEN : SHIFT_LEN;
    localparam int c_max_c  = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_max    = (c_max_c > OUT_LEN) ? c_max_c : OUT_LEN;
    localparam int c_cnt_w  = $clog2(c_max) + 1;

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_load     = 3'd1;
    localparam logic [2:0] c_compute  = 3'd2;
    localparam logic [2:0] c_transmit = 3'd3;
    localparam logic [2:0] c_shift    = 3'd4;
    localparam logic [2:0] c_output   = 3'd5;

    localparam logic [c_cnt_w-1:0]  c_load_last  = c_cnt_w'(LOAD_LEN - 1);
    localparam logic [c_cnt_w-1:0]  c_cmpt_last  = c_cnt_w'(CMPT_LEN - 1);
    localparam logic [c_cnt_w-1:0]  c_tx_last    = c_cnt_w'(TX_LEN - 1);
    localparam logic [c_cnt_w-1:0]  c_shift_last = c_cnt_w'(SHIFT_LEN - 1);
    localparam logic [c_cnt_w-1:0]  c_out_last   = c_cnt_w'(OUT_LEN - 1);
    localparam logic [c_iter_w-1:0] c_iter_last  = c_iter_w'(ITER_NUM - 1);

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_iter_w-1:0]     r_iter;
    logic [c_iter_w-1:0]     w_iter_nxt;
    logic                    r_samp_ready;
    logic                    r_din_pe_v;
    logic [2*DATA_WIDTH-1:0] r_din_pe;
    logic                    r_inst_go;
    logic                    r_tx_en;
    logic                    r_shift_en;
    logic                    r_alpha_v;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_run;
    logic                    w_accept;
    logic                    w_adv;
    logic                    w_last;
    logic                    w_samp_ready_nxt;
    logic                    w_inst_go_nxt;
    logic                    w_tx_en_nxt;
    logic                    w_shift_en_nxt;
    logic                    w_alpha_v_nxt;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;

`ifdef PE_SCHED_STALL_EN
    assign w_run = ~bus.stall;
`else
    logic w_stall_unused;
    assign w_stall_unused = bus.stall;
    assign w_run          = 1'b1;
`endif

    assign w_accept = r_samp_ready & bus.samp_in_v & w_run;

    // Window counters advance only on cycles the PE actually saw its strobe,
    // so a stall never shortens or lengthens a window.
    always_comb begin
        w_state_nxt = r_state;
        w_iter_nxt  = r_iter;
        w_adv       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_idle: begin
                if (bus.start && w_run) w_state_nxt = c_load;
            end
            c_load: begin
                w_adv  = w_accept;
                w_last = (r_cnt == c_load_last);
                if (w_adv && w_last) w_state_nxt = c_compute;
            end
            c_compute: begin
                w_adv  = r_inst_go;
                w_last = (r_cnt == c_cmpt_last);
                if (w_adv && w_last)
                    w_state_nxt = (r_iter == c_iter_last) ? c_output : c_transmit;
            end
            c_transmit: begin
                w_adv  = r_tx_en;
                w_last = (r_cnt == c_tx_last);
                if (w_adv && w_last) w_state_nxt = c_shift;
            end
            c_shift: begin
                w_adv  = r_shift_en;
                w_last = (r_cnt == c_shift_last);
                if (w_adv && w_last) begin
                    w_state_nxt = c_compute;
                    w_iter_nxt  = r_iter + 1'b1;
                end
            end
            c_output: begin
                w_adv  = r_alpha_v;
                w_last = (r_cnt == c_out_last);
                if (w_adv && w_last) begin
                    w_state_nxt = c_idle;
                    w_iter_nxt  = '0;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        w_samp_ready_nxt = (w_state_nxt == c_load)     && w_run;
        w_inst_go_nxt    = (w_state_nxt == c_compute)  && w_run;
        w_tx_en_nxt      = (w_state_nxt == c_transmit) && w_run;
        w_shift_en_nxt   = (w_state_nxt == c_shift)    && w_run;
        w_alpha_v_nxt    = (w_state_nxt == c_output)   && w_run;
        w_busy_nxt       = (w_state_nxt != c_idle);
        w_done_nxt       = (r_state == c_output) && (w_state_nxt == c_idle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_cnt        <= '0;
            r_iter       <= '0;
            r_samp_ready <= 1'b0;
            r_din_pe_v   <= 1'b0;
            r_din_pe     <= '0;
            r_inst_go    <= 1'b0;
            r_tx_en      <= 1'b0;
            r_shift_en   <= 1'b0;
            r_alpha_v    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_iter  <= w_iter_nxt;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (w_adv)             r_cnt <= r_cnt + 1'b1;
            r_din_pe_v <= w_accept;
            if (w_accept) r_din_pe <= bus.samp_in;
            r_samp_ready <= w_samp_ready_nxt;
            r_inst_go    <= w_inst_go_nxt;
            r_tx_en      <= w_tx_en_nxt;
            r_shift_en   <= w_shift_en_nxt;
            r_alpha_v    <= w_alpha_v_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.samp_ready = r_samp_ready;
    assign bus.din_pe_v   = r_din_pe_v;
    assign bus.din_pe     = r_din_pe;
    assign bus.inst_go    = r_inst_go;
    assign bus.tx_en      = r_tx_en;
    assign bus.shift_en   = r_shift_en;
    assign bus.alpha_v    = r_alpha_v;
    assign bus.iter_idx   = r_iter;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_pe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_scheduler
// Brief    : Directed bench for pe_scheduler (ITER_NUM=8 and ITER_NUM=1).
// Revision : 1.0
// ============================================================================
module tb_pe_scheduler;
    localparam int DW  = 16;
    localparam int IW0 = $clog2(8) + 1;
`ifdef PE_SCHED_STALL_EN
    localparam int STALL_DLY = 10;
`else
    localparam int STALL_DLY = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_scheduler_if #(.DATA_WIDTH(DW), .ITER_W(IW0)) bus0 ();
    pe_scheduler_if #(.DATA_WIDTH(DW), .ITER_W(1))   bus1 ();

    pe_scheduler #(.DATA_WIDTH(DW), .ITER_NUM(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pe_scheduler #(.DATA_WIDTH(DW), .ITER_NUM(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int go_tot, tx_tot, sh_tot, al_tot, done_cnt, excl_err, iter_err, drop_err;
    int comp_entries, first_go_len, t_done;

    typedef struct {
        logic        start;
        logic        vin;
        logic [31:0] din;
        logic        e_ready;
        logic        e_dv;
        logic [31:0] e_dout;
        logic        e_go;
        logic        e_busy;
    } vec_t;
    vec_t vt[40];
    int   nv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Back-to-back load of samples 0x00010001..0x00100010 into the 8-iteration DUT.
    task automatic load0(output int t_acc);
        int errs = 0;
        bus0.start = 1'b1; bus0.samp_in_v = 1'b0;
        step();
        bus0.start = 1'b0;
        chk("load.ready_after_start", bus0.samp_ready, 1);
        t_acc = cyc;
        for (int k = 1; k <= 16; k++) begin
            bus0.samp_in_v = 1'b1;
            bus0.samp_in   = {16'(k), 16'(k)};
            step();
            if (bus0.din_pe_v !== 1'b1 || bus0.din_pe !== {16'(k), 16'(k)}) errs++;
            if (bus0.inst_go !== (k == 16)) errs++;
            if (bus0.samp_ready !== (k < 16)) errs++;
        end
        bus0.samp_in_v = 1'b0;
        chk("load.seq_errors", errs, 0);
        chk("load.iter_at_entry", bus0.iter_idx, 0);
    endtask

    task automatic mon0(input int go_init, input int stall_at, input bit poke);
        int   stall_left = 0;
        bit   stalled = 0;
        int   cur_run = go_init;
        logic prev_go = (go_init > 0);
        go_tot = go_init; tx_tot = 0; sh_tot = 0; al_tot = 0; done_cnt = 0;
        excl_err = 0; iter_err = 0; drop_err = 0; first_go_len = 0; t_done = -1;
        comp_entries = (go_init > 0) ? 1 : 0;
        for (int n = 0; n < 3000; n++) begin
            bus0.stall     = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            bus0.start     = poke && (bus0.inst_go || bus0.alpha_v) && (n % 5 == 2);
            bus0.samp_in_v = 1'b1;
            bus0.samp_in   = 32'hFFFF_0000;
            step();
            if (bus0.din_pe_v) drop_err++;
            if (int'(bus0.samp_ready) + int'(bus0.inst_go) + int'(bus0.tx_en)
                + int'(bus0.shift_en) + int'(bus0.alpha_v) > 1) excl_err++;
            if (bus0.inst_go) begin go_tot++; cur_run++; end
            if (bus0.inst_go && !prev_go) begin
                if (int'(bus0.iter_idx) != comp_entries) iter_err++;
                comp_entries++;
            end
            if (!bus0.inst_go && prev_go && first_go_len == 0) first_go_len = cur_run;
            prev_go = bus0.inst_go;
            tx_tot += int'(bus0.tx_en);
            sh_tot += int'(bus0.shift_en);
            al_tot += int'(bus0.alpha_v);
            if (bus0.done) begin done_cnt++; if (t_done < 0) t_done = cyc; end
            if (stall_at >= 0 && !stalled && go_tot == stall_at + 1) begin
                stall_left = 10; stalled = 1;
            end
            if (t_done >= 0 && cyc == t_done + 1) break;
        end
        bus0.start = 1'b0; bus0.samp_in_v = 1'b0; bus0.stall = 1'b0;
    endtask

    task automatic post(input string tag, input int t_acc, input int exp_lat, input bit full);
        chk({tag, ".done_count"}, done_cnt, 1);
        chk({tag, ".inst_go_total"}, go_tot, 512);
        chk({tag, ".tx_total"}, tx_tot, 28);
        chk({tag, ".shift_total"}, sh_tot, 56);
        chk({tag, ".alpha_total"}, al_tot, 4);
        chk({tag, ".exclusive_err"}, excl_err, 0);
        chk({tag, ".dropped_err"}, drop_err, 0);
        chk({tag, ".latency"}, t_done - t_acc, exp_lat);
        chk({tag, ".after_done_busy_done_iter"}, {bus0.busy, bus0.done, bus0.iter_idx}, 0);
        if (full) begin
            chk({tag, ".first_window"}, first_go_len, 64);
            chk({tag, ".iter_err"}, iter_err, 0);
            chk({tag, ".compute_entries"}, comp_entries, 8);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_acc, t1, go1, tx1, sh1, al1, last_go, first_al, td1, shc;
        bit found;
        bus0.start = 0; bus0.samp_in_v = 0; bus0.samp_in = '0; bus0.stall = 0;
        bus1.start = 0; bus1.samp_in_v = 0; bus1.samp_in = '0; bus1.stall = 0;

        // Toggling load: accepts on alternate cycles, start ignored in COMPUTE.
        nv = 0;
        vt[nv++] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0};
        vt[nv++] = '{1, 0, 32'h0, 1, 0, 32'h0, 0, 1};
        for (int k = 1; k <= 16; k++) begin
            vt[nv++] = '{0, 1, {16'(k), 16'(k)}, (k < 16), 1, {16'(k), 16'(k)}, (k == 16), 1};
            if (k < 16) vt[nv++] = '{0, 0, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 1};
        end
        vt[nv++] = '{1, 1, 32'hBAD0_0BAD, 0, 0, 32'h0, 1, 1};

        repeat (3) step();
        chk("reset.dut0_outputs", {bus0.samp_ready, bus0.din_pe_v, bus0.din_pe, bus0.inst_go,
            bus0.tx_en, bus0.shift_en, bus0.alpha_v, bus0.iter_idx, bus0.busy, bus0.done}, 0);
        chk("reset.dut1_outputs", {bus1.samp_ready, bus1.din_pe_v, bus1.inst_go, bus1.alpha_v,
            bus1.busy, bus1.done}, 0);
        rst = 1'b0;

        t_acc = 0;
        for (int i = 0; i < nv; i++) begin
            bus0.start = vt[i].start; bus0.samp_in_v = vt[i].vin; bus0.samp_in = vt[i].din;
            if (i == 2) t_acc = cyc;
            step();
            chk($sformatf("vec%0d.samp_ready", i), bus0.samp_ready, vt[i].e_ready);
            chk($sformatf("vec%0d.din_pe_v", i), bus0.din_pe_v, vt[i].e_dv);
            if (vt[i].e_dv) chk($sformatf("vec%0d.din_pe", i), bus0.din_pe, vt[i].e_dout);
            chk($sformatf("vec%0d.inst_go", i), bus0.inst_go, vt[i].e_go);
            chk($sformatf("vec%0d.busy", i), bus0.busy, vt[i].e_busy);
            chk($sformatf("vec%0d.done", i), bus0.done, 0);
        end
        mon0(2, -1, 1'b1);
        post("toggle", t_acc, 631, 1'b1);

        load0(t_acc);
        mon0(1, -1, 1'b1);
        post("b2b", t_acc, 616, 1'b1);

        load0(t_acc);
        mon0(1, 20, 1'b0);
        post("stall", t_acc, 616 + STALL_DLY, 1'b0);

        // Reset on the 5th SHIFT cycle of iteration 3, then a clean rerun.
        load0(t_acc);
        shc = 0; found = 0;
        for (int n = 0; n < 3000; n++) begin
            step();
            if (bus0.shift_en && bus0.iter_idx == 3) shc++;
            if (shc == 5) begin found = 1; break; end
        end
        chk("rst.reached_shift5", found, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst.outputs_zero", {bus0.samp_ready, bus0.din_pe_v, bus0.inst_go, bus0.tx_en,
            bus0.shift_en, bus0.alpha_v, bus0.iter_idx, bus0.busy, bus0.done}, 0);
        shc = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            shc += int'(bus0.done) + int'(bus0.busy);
        end
        chk("rst.no_done_no_busy", shc, 0);
        load0(t_acc);
        mon0(1, -1, 1'b0);
        post("rerun", t_acc, 616, 1'b1);

        // ITER_NUM=1: LOAD, COMPUTE, OUTPUT only.
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        t1 = cyc;
        for (int k = 1; k <= 16; k++) begin
            bus1.samp_in_v = 1'b1; bus1.samp_in = {16'(k), 16'(k)};
            step();
        end
        bus1.samp_in_v = 1'b0;
        go1 = int'(bus1.inst_go); last_go = bus1.inst_go ? cyc : -1;
        tx1 = 0; sh1 = 0; al1 = 0; first_al = -1; td1 = -1;
        for (int n = 0; n < 500; n++) begin
            step();
            if (bus1.inst_go) begin go1++; last_go = cyc; end
            if (bus1.alpha_v) begin al1++; if (first_al < 0) first_al = cyc; end
            tx1 += int'(bus1.tx_en);
            sh1 += int'(bus1.shift_en);
            if (bus1.done && td1 < 0) td1 = cyc;
            if (td1 >= 0 && cyc == td1 + 1) break;
        end
        chk("iter1.inst_go_total", go1, 64);
        chk("iter1.tx_total", tx1, 0);
        chk("iter1.shift_total", sh1, 0);
        chk("iter1.alpha_total", al1, 4);
        chk("iter1.alpha_follows_go", first_al, last_go + 1);
        chk("iter1.latency", td1 - t1, 84);
        chk("iter1.after_done_busy", {bus1.busy, bus1.done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
